// File: rtl/reg_pkg.sv
// ---------------------------------------------------------------------------
// reg_pkg -- shared types for the register-file writeback path.
//   XLEN        : data width of a register write
//   REG_ADDR_W  : register index width (register 0 is hardwired, never written)
//   wb_entry_t  : one queued register write {addr, data}
//   src_e       : identifies which producer owns the arbiter grant
// ---------------------------------------------------------------------------
package reg_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  typedef struct packed {
    reg_addr_t addr;
    xdata_t    data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage : reg_pkg

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo -- circular queue of pending register writes.
//   clk, rst_n            : clock, asynchronous active-low reset
//   push_i, push_entry_i  : enqueue an entry at the tail (ignored when full)
//   pop_i                 : dequeue the head (ignored when empty)
//   full_o, empty_o       : occupancy flags
//   count_o               : number of occupied entries (0..DEPTH)
//   head_o                : oldest entry, combinational from storage
//   cmp_addr0/1_i         : register indices to search for
//   match0/1_o            : per-slot hit vectors, only occupied slots can hit
// ---------------------------------------------------------------------------
module wb_fifo
  import reg_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output wb_entry_t        head_o,
  input  reg_addr_t        cmp_addr0_i,
  input  reg_addr_t        cmp_addr1_i,
  output logic [DEPTH-1:0] match0_o,
  output logic [DEPTH-1:0] match1_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] occupied;
  logic [PTR_W-1:0] offset;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against over/underflow even if the caller misbehaves.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by count/pointers, so
  // stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the current count. The head slot popping this cycle still hits.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    occupied = '0;
    match0_o = '0;
    match1_o = '0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset      = PTR_W'(i) - rd_ptr_q;
      occupied[i] = ({1'b0, offset} < count_q);
      match0_o[i] = occupied[i] && (mem_q[i].addr == cmp_addr0_i);
      match1_o[i] = occupied[i] && (mem_q[i].addr == cmp_addr1_i);
    end
  end

endmodule : wb_fifo

// File: rtl/reg_wb.sv
// ---------------------------------------------------------------------------
// reg_wb -- register-file writeback stage.
// Two producers (ALU results, load results) feed a shared writeback queue
// through a round-robin arbiter; the queue drains into the single register
// file write port whenever it is not stalled.
//   clk, rst_n                              : clock, async active-low reset
//   alu_valid/alu_ready/alu_addr/alu_data   : ALU result handshake
//   mem_valid/mem_ready/mem_addr/mem_data   : load result handshake
//   wb_stall                                : write port busy this cycle
//   wb_waddr/wb_wdata/wb_wren               : register file write port
//   pend_addr0/pend0, pend_addr1/pend1      : hazard query, 1 when a write to
//                                             that register is still queued
// Writes to register 0 complete their handshake but are dropped.
// ---------------------------------------------------------------------------
module reg_wb
  import reg_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_stall,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]       wb_wdata,
  output logic                  wb_wren,
  input  logic [REG_ADDR_W-1:0] pend_addr0,
  output logic                  pend0,
  input  logic [REG_ADDR_W-1:0] pend_addr1,
  output logic                  pend1
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Arbiter and reset-release state.
  src_e last_q, last_d;
  logic init_q;  // 0 from reset until the first edge after release

  // Queue interface.
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        fifo_head;
  wb_entry_t        push_entry;
  logic             push;
  logic [DEPTH-1:0] match0;
  logic [DEPTH-1:0] match1;

  logic grant_alu;
  logic grant_mem;
  logic has_room;
  logic xfer;

  // Round-robin: a lone requester wins; on contention the source that did
  // not win the last completed transfer wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_valid && mem_valid) begin
      grant_alu = (last_q == SRC_MEM);
      grant_mem = (last_q == SRC_ALU);
    end else begin
      grant_alu = alu_valid;
      grant_mem = mem_valid;
    end
  end

  // Room is judged on the current count only: a pop in the same cycle does
  // not open a slot until the following cycle.
  assign has_room  = init_q && (fifo_count < CNT_W'(DEPTH));
  assign alu_ready = grant_alu && has_room;
  assign mem_ready = grant_mem && has_room;
  assign xfer      = (alu_valid && alu_ready) || (mem_valid && mem_ready);

  always_comb begin
    push_entry.addr = alu_addr;
    push_entry.data = alu_data;
    if (grant_mem) begin
      push_entry.addr = mem_addr;
      push_entry.data = mem_data;
    end
  end

  // Register 0 is never written, so such transfers are simply absorbed.
  assign push = xfer && (push_entry.addr != '0);

  // The grant flag only moves when a transfer actually completes.
  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = grant_mem ? SRC_MEM : SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_MEM;  // ALU wins the first contended cycle
      init_q <= 1'b0;
    end else begin
      last_q <= last_d;
      init_q <= 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (wb_wren),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .head_o       (fifo_head),
    .cmp_addr0_i  (pend_addr0),
    .cmp_addr1_i  (pend_addr1),
    .match0_o     (match0),
    .match1_o     (match1)
  );

  // Write port: head entry straight from storage; enable gated by stall.
  assign wb_waddr = fifo_head.addr;
  assign wb_wdata = fifo_head.data;
  assign wb_wren  = !fifo_empty && !wb_stall;

  // Register 0 is never pending, even if a stale slot holds index 0.
  assign pend0 = (pend_addr0 != '0) && (|match0);
  assign pend1 = (pend_addr1 != '0) && (|match1);

  // Full flag and count must always agree.
  a_full_consistent : assert property (
    @(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == CNT_W'(DEPTH))
  );

endmodule : reg_wb

// File: tb/tb_reg_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_wb -- self-checking bench for reg_wb. A queue-based reference model
// predicts readies, the write port and the hazard outputs every cycle.
// ---------------------------------------------------------------------------
module tb_reg_wb;
  import reg_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid, alu_ready, mem_valid, mem_ready;
  reg_addr_t       alu_addr, mem_addr, wb_waddr, pend_addr0, pend_addr1;
  xdata_t          alu_data, mem_data, wb_wdata;
  logic            wb_stall, wb_wren, pend0, pend1;

  always #5 clk = ~clk;

  reg_wb #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .wb_stall   (wb_stall),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .wb_wren    (wb_wren),
    .pend_addr0 (pend_addr0),
    .pend0      (pend0),
    .pend_addr1 (pend_addr1),
    .pend1      (pend1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  wb_entry_t mq[$];          // queued writes, oldest first
  bit        m_last_mem;     // last completed transfer came from MEM
  bit        m_init;         // readies allowed (first edge after reset seen)

  // Producer state.
  wb_entry_t alu_src[$], mem_src[$];
  bit        alu_v_r, mem_v_r;
  wb_entry_t alu_cur, mem_cur;
  bit        stall_r;
  reg_addr_t pa0_r, pa1_r;
  int        gap_pct;
  wb_entry_t seen[$];        // writes observed on the port
  wb_entry_t exp_q[$];

  function automatic wb_entry_t mk(input int a, input logic [31:0] d);
    wb_entry_t e;
    e.addr = 5'(a);
    e.data = d;
    return e;
  endfunction

  function automatic bit model_pend(input reg_addr_t a);
    if (a == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy();
    return (mq.size() != 0) || alu_v_r || mem_v_r || (alu_src.size() != 0) || (mem_src.size() != 0);
  endfunction

  task automatic cycle();
    bit g_alu, g_mem, room, e_ar, e_mr, e_wren;
    @(negedge clk);
    if (!alu_v_r && alu_src.size() > 0 && $urandom_range(99) >= gap_pct) begin
      alu_cur = alu_src.pop_front();
      alu_v_r = 1'b1;
    end
    if (!mem_v_r && mem_src.size() > 0 && $urandom_range(99) >= gap_pct) begin
      mem_cur = mem_src.pop_front();
      mem_v_r = 1'b1;
    end
    alu_valid = alu_v_r; alu_addr = alu_cur.addr; alu_data = alu_cur.data;
    mem_valid = mem_v_r; mem_addr = mem_cur.addr; mem_data = mem_cur.data;
    wb_stall = stall_r; pend_addr0 = pa0_r; pend_addr1 = pa1_r;
    #1;
    if (alu_v_r && mem_v_r) begin
      g_alu = m_last_mem;
      g_mem = !m_last_mem;
    end else begin
      g_alu = alu_v_r;
      g_mem = mem_v_r;
    end
    room   = m_init && (mq.size() < DEPTH);
    e_ar   = g_alu && room;
    e_mr   = g_mem && room;
    e_wren = (mq.size() > 0) && !stall_r;
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("mem_ready", 32'(mem_ready), 32'(e_mr));
    check("wb_wren", 32'(wb_wren), 32'(e_wren));
    if (e_wren) begin
      check("wb_waddr", 32'(wb_waddr), 32'(mq[0].addr));
      check("wb_wdata", wb_wdata, mq[0].data);
    end
    check("pend0", 32'(pend0), 32'(model_pend(pa0_r)));
    check("pend1", 32'(pend1), 32'(model_pend(pa1_r)));
    if (wb_wren === 1'b1) seen.push_back(mk(int'(wb_waddr), wb_wdata));
    @(posedge clk);
    if (e_wren) void'(mq.pop_front());
    if (e_ar) begin
      if (alu_cur.addr != 0) mq.push_back(alu_cur);
      m_last_mem = 1'b0;
      alu_v_r = 1'b0;
    end else if (e_mr) begin
      if (mem_cur.addr != 0) mq.push_back(mem_cur);
      m_last_mem = 1'b1;
      mem_v_r = 1'b0;
    end
    m_init = 1'b1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int n = 0; n < max_cycles && busy(); n++) cycle();
    check({tag, "_drain_timeout"}, 32'(busy()), 0);
  endtask

  task automatic cmp_seen(input string tag);
    check({tag, "_count"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(seen[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_data%0d", tag, i), seen[i].data, exp_q[i].data);
    end
    seen.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd30; alu_data = 32'hdead;
    mem_valid = 1'b1; mem_addr = 5'd31;
    rst_n = 1'b0;
    #1;
    check("rst_wren", 32'(wb_wren), 0);
    check("rst_alu_ready", 32'(alu_ready), 0);
    check("rst_mem_ready", 32'(mem_ready), 0);
    check("rst_pend0", 32'(pend0), 0);
    check("rst_pend1", 32'(pend1), 0);
    mq.delete(); m_last_mem = 1'b1; m_init = 1'b0;
    alu_v_r = 1'b0; mem_v_r = 1'b0; alu_src.delete(); mem_src.delete();
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_alu_ready", 32'(alu_ready), 0);
    check("rel_wren", 32'(wb_wren), 0);
    @(posedge clk);
    m_init = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alu_valid = 0; mem_valid = 0; alu_addr = 0; mem_addr = 0; alu_data = 0; mem_data = 0;
    wb_stall = 0; pend_addr0 = 0; pend_addr1 = 0;
    alu_cur = mk(0, 0); mem_cur = mk(0, 0);
    stall_r = 0; pa0_r = 0; pa1_r = 0; gap_pct = 0;
    do_reset();

    // Single ALU write, one-cycle writeback latency, hazard until pop.
    pa0_r = 5'd5;
    alu_src.push_back(mk(5, 32'h1234));
    drain("single", 20);
    exp_q.push_back(mk(5, 32'h1234));
    cmp_seen("single");

    // Both producers every cycle: grants alternate starting with ALU.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu_src.push_back(mk(1 + i, 32'h100 + i));
      mem_src.push_back(mk(9 + i, 32'h200 + i));
    end
    pa0_r = 5'd2; pa1_r = 5'd11;
    drain("rr", 40);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1 + i, 32'h100 + i));
      exp_q.push_back(mk(9 + i, 32'h200 + i));
    end
    cmp_seen("rr");

    // Stalled port: queue fills at DEPTH, readiness returns after a pop.
    stall_r = 1'b1;
    for (int i = 0; i < 5; i++) alu_src.push_back(mk(13 + i, 32'hA0 + i));
    repeat (8) cycle();
    check("full_alu_ready", 32'(alu_ready), 0);
    stall_r = 1'b0;
    drain("stall", 30);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(13 + i, 32'hA0 + i));
    cmp_seen("stall");

    // Writes to register 0 are absorbed.
    pa0_r = 5'd0; pa1_r = 5'd7;
    for (int i = 0; i < 3; i++) begin
      alu_src.push_back(mk(0, 32'hF0 + i));
      alu_src.push_back(mk(7, 32'h70 + i));
    end
    drain("zero", 40);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(7, 32'h70 + i));
    cmp_seen("zero");

    // Same register written three times: retire in order.
    pa1_r = 5'd3;
    stall_r = 1'b1;
    for (int i = 1; i <= 3; i++) alu_src.push_back(mk(3, i));
    repeat (5) cycle();
    stall_r = 1'b0;
    drain("same", 20);
    for (int i = 1; i <= 3; i++) exp_q.push_back(mk(3, i));
    cmp_seen("same");

    // Reset with three entries queued discards them.
    stall_r = 1'b1;
    pa0_r = 5'd20;
    for (int i = 0; i < 3; i++) alu_src.push_back(mk(20 + i, 32'hC0 + i));
    repeat (5) cycle();
    do_reset();
    stall_r = 1'b0;
    alu_src.push_back(mk(25, 32'h2525));
    drain("reset", 20);
    exp_q.push_back(mk(25, 32'h2525));
    cmp_seen("reset");

    // Randomized traffic against the model.
    gap_pct = 30;
    for (int c = 0; c < 1500; c++) begin
      if (alu_src.size() < 2 && $urandom_range(1) == 1)
        alu_src.push_back(mk($urandom_range(0, 7), $urandom));
      if (mem_src.size() < 2 && $urandom_range(1) == 1)
        mem_src.push_back(mk($urandom_range(0, 7), $urandom));
      stall_r = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) pa0_r = 5'($urandom_range(0, 7));
      if ($urandom_range(7) == 0) pa1_r = 5'($urandom_range(0, 7));
      cycle();
    end
    stall_r = 1'b0;
    gap_pct = 0;
    drain("random", 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_wb

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 Parameter: DEPTH, default 4, writeback queue entries; power of two, minimum 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 alu_valid  in  1; alu_ready  out  1; alu_addr  in  5; alu_data  in  32: ALU result producer.
REQ-005 mem_valid  in  1; mem_ready  out  1; mem_addr  in  5; mem_data  in  32: load result producer.
REQ-006 wb_stall  in  1  register-file write port unavailable this cycle.
REQ-007 wb_waddr  out  5; wb_wdata  out  32; wb_wren  out  1: drive the register file write port.
REQ-008 pend_addr0  in  5; pend0  out  1; pend_addr1  in  5; pend1  out  1: hazard query, queued write pending for that register.

Function
REQ-009 Handshake: a transfer occurs on a rising edge when valid and ready are both 1; the producer holds addr/data stable while valid=1 and ready=0.
REQ-010 At most one producer is accepted per cycle; the arbiter is round-robin with a 1-bit last-grant flag.
REQ-011 Grant: if only one source is valid, it is granted; if both are valid, the source not granted last is granted; the flag updates only on a completed transfer.
REQ-012 ready = granted AND (count < DEPTH), combinational; the non-granted source has ready=0.
REQ-013 Transfer with addr=0 completes the handshake but is not enqueued; count and wb outputs are unaffected.
REQ-014 Transfer with addr!=0 enqueues {addr,data} at the tail in arrival order.
REQ-015 wb_waddr/wb_wdata = head entry, combinational from storage; wb_wren = (count>0) AND NOT wb_stall.
REQ-016 Pop on each edge where wb_wren=1; minimum latency: accepted at edge N -> wb_wren=1 in the cycle after N -> register written at edge N+1.
REQ-017 Simultaneous push and pop: count unchanged; with count=1 the pushed entry becomes the head next cycle.
REQ-018 Full (count=DEPTH): both readies are 0; no push-through on a same-cycle pop; ready rises in the cycle after the pop.
REQ-019 Empty: wb_wren=0; wb_waddr/wb_wdata are don't-care.
REQ-020 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-021 pendK=1 iff pend_addrK!=0 and any occupied entry holds addr=pend_addrK; combinational; the entry popping this cycle still counts.
REQ-022 Multiple queued writes to one address are legal and retire in order, so the last-written value wins.

Reset
REQ-023 rst_n=0 asynchronously clears count, pointers, and last-grant (ALU preferred first).
REQ-024 During and after reset: wb_wren=0, alu_ready=0 until the first edge after deassertion, pend0=pend1=0; queue storage is not cleared.
REQ-025 Reset mid-operation discards all queued entries without writing them.

Structure
REQ-026 Shared package reg_pkg holds XLEN=32, REG_ADDR_W=5, and the wb entry type {addr,data}.
REQ-027 The queue is a sub-module wb_fifo (parameter DEPTH; push/pop/full/empty/count, head output, per-entry addr compare vector); arbitration and hazard logic stay in reg_wb.

Verification
REQ-028 Single ALU write addr=5 data=0x1234, no stall -> wb_wren=1 with waddr=5, wdata=0x1234 exactly one cycle after acceptance; pend0 (pend_addr0=5) is 1 until the pop.
REQ-029 Both producers valid every cycle (ALU addr 1..4, MEM addr 9..12), no stall -> grants alternate ALU, MEM, ALU...; the wb sequence is 1,9,2,10,3,11,4,12.
REQ-030 wb_stall=1 while pushing 5 writes with DEPTH=4 -> 4 accepted, then ready=0; release stall -> ready=1 in the cycle after the first pop; writes retire in order.
REQ-031 Writes to addr 0 interleaved with addr 7 -> all handshakes complete; only addr 7 appears on the wb port; pend for addr 0 is always 0.
REQ-032 rst_n asserted with 3 entries queued -> wb_wren=0 immediately, count=0; after release the first accepted write is the next one to appear on the wb port.
REQ-033 Three queued writes to addr 3 (values 1, 2, 3) -> retire in order 1, 2, 3; pend stays 1 until the last pop.
